// File: rtl/bitrev_reorder_buffer_if.sv
// Sample stream bundle between the SDF output stage, the reorder buffer and its consumer.
// di_* carries bit-reversed-order samples in; do_* carries natural-order samples out.
interface bitrev_reorder_buffer_if #(
    parameter int WIDTH = 16
);
    logic             di_en;
    logic [WIDTH-1:0] di_re;
    logic [WIDTH-1:0] di_im;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;

    modport master (
        output di_en, di_re, di_im,
        input  do_en, do_re, do_im
    );

    modport slave (
        input  di_en, di_re, di_im,
        output do_en, do_re, do_im
    );
endinterface

// File: rtl/bitrev_reorder_buffer.sv
// Ping-pong RAM turning bit-reversed FFT frames into natural order; X[0] appears 2 cycles
// after a frame's last input, then N samples back-to-back. No backpressure: 1 sample/cycle.
module bitrev_reorder_buffer #(
    parameter int LOG_N = 6,
    parameter int WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    bitrev_reorder_buffer_if.slave bus
);
    localparam int N = 1 << LOG_N;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) begin
            r[i] = a[LOG_N-1-i];
        end
        return r;
    endfunction

    logic [2*WIDTH-1:0] mem [2*N];

    logic [LOG_N-1:0]   wcnt_q, wcnt_d;
    logic               wbank_q, wbank_d;
    logic               frame_done_q, frame_done_d;

    state_t             state_q;
    logic [LOG_N-1:0]   rcnt_q;
    logic               rbank_q;
    logic               do_en_q;
    logic [2*WIDTH-1:0] rd_dat_q;

    logic               rd_issue;
    logic [LOG_N:0]     raddr;
    logic [LOG_N:0]     waddr;

    // ---------------- write side ----------------
    always_comb begin
        wcnt_d       = wcnt_q;
        wbank_d      = wbank_q;
        frame_done_d = 1'b0;
        if (bus.di_en) begin
            wcnt_d = wcnt_q + 1'b1;
            if (&wcnt_q) begin
                wbank_d      = ~wbank_q;
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt_q       <= '0;
            wbank_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wcnt_q       <= wcnt_d;
            wbank_q      <= wbank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign waddr = {wbank_q, bitrev(wcnt_q)};

    always_ff @(posedge clock) begin
        if (bus.di_en && !reset) begin
            mem[waddr] <= {bus.di_re, bus.di_im};
        end
    end

    // ---------------- read side ----------------
    // frame_done_q is one cycle behind the bank toggle, so ~wbank_q names the bank just filled.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            rbank_q <= 1'b0;
            do_en_q <= 1'b0;
        end else begin
            do_en_q <= (state_q == READ);
            case (state_q)
                IDLE: begin
                    if (frame_done_q) begin
                        state_q <= READ;
                        rbank_q <= ~wbank_q;
                        rcnt_q  <= '0;
                    end
                end
                READ: begin
                    rcnt_q <= rcnt_q + 1'b1;
                    if (&rcnt_q) begin
                        if (frame_done_q) begin
                            rbank_q <= ~wbank_q;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_issue = (state_q == READ);
    assign raddr    = {rbank_q, rcnt_q};

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_dat_q <= '0;
        end else if (rd_issue) begin
            rd_dat_q <= mem[raddr];
        end
    end

    assign bus.do_en = do_en_q;
    assign bus.do_re = rd_dat_q[2*WIDTH-1:WIDTH];
    assign bus.do_im = rd_dat_q[WIDTH-1:0];
endmodule

// File: tb/tb_bitrev_reorder_buffer.sv
// Drives an 8-point and a 64-point reorder buffer with the same stream and compares each
// output cycle against a frame-level model: output k of a frame is the input taken at position bitrev(k).
module tb_bitrev_reorder_buffer;
    localparam int W = 16;

    typedef struct {
        int          due;
        logic [31:0] dat;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bitrev_reorder_buffer_if #(.WIDTH(W)) bus3 ();
    bitrev_reorder_buffer_if #(.WIDTH(W)) bus6 ();

    bitrev_reorder_buffer #(.LOG_N(3), .WIDTH(W)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    bitrev_reorder_buffer #(.LOG_N(6), .WIDTH(W)) dut6 (
        .clock (clock),
        .reset (reset),
        .bus   (bus6)
    );

    exp_t        q3[$];
    exp_t        q6[$];
    logic [31:0] fbuf [2][64];
    int          fill [2];
    logic [31:0] last [2];
    bit          mon_on [2];
    int          edge_cnt;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", tag, obs, exp, edge_cnt);
        end
    endtask

    function automatic int ref_rev(input int v, input int bits);
        int r = 0;
        int x = v;
        for (int b = 0; b < bits; b++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    // Called just after a negedge: outputs reflect the edge numbered edge_cnt.
    task automatic monitor(input int d);
        logic        en;
        logic [31:0] dat;
        bit          have;
        exp_t        e;
        if (!mon_on[d]) return;
        have = 1'b0;
        if (d == 0) begin
            en  = bus3.do_en;
            dat = {bus3.do_re, bus3.do_im};
            if (q3.size() > 0 && q3[0].due == edge_cnt) begin
                have = 1'b1;
                e = q3.pop_front();
            end
        end else begin
            en  = bus6.do_en;
            dat = {bus6.do_re, bus6.do_im};
            if (q6.size() > 0 && q6[0].due == edge_cnt) begin
                have = 1'b1;
                e = q6.pop_front();
            end
        end
        if (have) begin
            check($sformatf("n%0d do_en active", d ? 64 : 8), 64'(en), 64'(1));
            check($sformatf("n%0d do_data", d ? 64 : 8), 64'(dat), 64'(e.dat));
            last[d] = e.dat;
        end else begin
            check($sformatf("n%0d do_en idle", d ? 64 : 8), 64'(en), 64'(0));
            check($sformatf("n%0d hold_data", d ? 64 : 8), 64'(dat), 64'(last[d]));
        end
    endtask

    task automatic model(input int d, input bit rst, input bit en, input logic [31:0] dat);
        int   n;
        int   lg;
        exp_t e;
        n  = (d != 0) ? 64 : 8;
        lg = (d != 0) ? 6 : 3;
        if (rst) begin
            fill[d]   = 0;
            mon_on[d] = 1'b1;
            last[d]   = '0;
            if (d == 0) begin
                while (q3.size() > 0 && q3[$].due >= edge_cnt) void'(q3.pop_back());
            end else begin
                while (q6.size() > 0 && q6[$].due >= edge_cnt) void'(q6.pop_back());
            end
            return;
        end
        if (en) begin
            fbuf[d][fill[d]] = dat;
            fill[d]++;
            if (fill[d] == n) begin
                for (int k = 0; k < n; k++) begin
                    e.due = edge_cnt + 2 + k;
                    e.dat = fbuf[d][ref_rev(k, lg)];
                    if (d == 0) q3.push_back(e);
                    else        q6.push_back(e);
                end
                fill[d] = 0;
            end
        end
    endtask

    task automatic step(input bit rst, input bit en, input logic [15:0] re, input logic [15:0] im);
        monitor(0);
        monitor(1);
        reset      = rst;
        bus3.di_en = en;
        bus3.di_re = re;
        bus3.di_im = im;
        bus6.di_en = en;
        bus6.di_re = re;
        bus6.di_im = im;
        @(posedge clock);
        edge_cnt++;
        model(0, rst, en, {re, im});
        model(1, rst, en, {re, im});
        @(negedge clock);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(1'b0, 1'b0, 16'($urandom), 16'($urandom));
        end
    endtask

    // One 8-point frame whose natural-order content is base..base+7, presented bit-reversed.
    task automatic send_frame(input int base, input bit gapped);
        int v;
        for (int j = 0; j < 8; j++) begin
            v = base + ref_rev(j, 3);
            step(1'b0, 1'b1, 16'(v), 16'(-v));
            if (gapped) step(1'b0, 1'b0, 16'($urandom), 16'($urandom));
        end
    endtask

    initial begin
        edge_cnt   = 0;
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        bus3.di_en = 1'b0;
        bus3.di_re = '0;
        bus3.di_im = '0;
        bus6.di_en = 1'b0;
        bus6.di_re = '0;
        bus6.di_im = '0;
        for (int d = 0; d < 2; d++) begin
            fill[d]   = 0;
            last[d]   = '0;
            mon_on[d] = 1'b0;
        end
        @(negedge clock);
        repeat (3) step(1'b1, 1'b0, '0, '0);

        send_frame(0, 1'b0);
        idle(12);

        for (int k = 0; k < 4; k++) send_frame(8 * k, 1'b0);
        idle(12);

        send_frame(0, 1'b1);
        idle(12);

        for (int j = 0; j < 5; j++) step(1'b0, 1'b1, 16'(50 + j), 16'(-(50 + j)));
        repeat (2) step(1'b1, 1'b0, '0, '0);
        send_frame(100, 1'b0);
        idle(12);

        // Reset lands while the third output sample is on the bus.
        send_frame(200, 1'b0);
        idle(4);
        step(1'b1, 1'b0, '0, '0);
        send_frame(300, 1'b0);
        idle(12);

        repeat (2) step(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 640; i++) begin
            step(1'b0, 1'b1, 16'($urandom), 16'($urandom));
        end
        idle(80);

        check("n8 queue drained", 64'(q3.size()), 64'(0));
        check("n64 queue drained", 64'(q6.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
